// File: rtl/mig_pkg.sv
// -----------------------------------------------------------------------------
// mig_pkg
// Shared types and helpers for the MIG stream evaluator.
//   lit_t            : literal {index, complement} at the default index width
//   state_t          : evaluator FSM states
//   CONST0_IDX       : table index that always reads as constant 0
//   lit_idx/lit_cmp  : split a literal into its index and complement bit
//   first_node_idx   : table index of the first MAJ node for a given PI count
// -----------------------------------------------------------------------------
package mig_pkg;

  localparam int CONST0_IDX = 0;
  localparam int LIT_IDX_W  = 8;

  typedef logic [LIT_IDX_W:0] lit_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EVAL,
    ST_DRAIN,
    ST_RESOLVE
  } state_t;

  // Literals are passed zero-extended to 32 bits so the helpers work for any
  // instance index width.
  function automatic logic [31:0] lit_idx(input logic [31:0] lit);
    return {1'b0, lit[31:1]};
  endfunction

  function automatic logic lit_cmp(input logic [31:0] lit);
    return lit[0];
  endfunction

  function automatic int unsigned first_node_idx(input int unsigned num_pi);
    return num_pi + 1;
  endfunction

endpackage

// File: rtl/mig_maj3.sv
// -----------------------------------------------------------------------------
// mig_maj3
// Combinational 3-input majority with a complement control per input.
//   i_a/i_b/i_c     : raw fanin values from the value table
//   i_ca/i_cb/i_cc  : complement bits (1 inverts the matching fanin)
//   o_y             : MAJ(a^ca, b^cb, c^cc)
// -----------------------------------------------------------------------------
module mig_maj3 (
  input  logic i_a,
  input  logic i_b,
  input  logic i_c,
  input  logic i_ca,
  input  logic i_cb,
  input  logic i_cc,
  output logic o_y
);

  logic w_va;
  logic w_vb;
  logic w_vc;

  assign w_va = i_a ^ i_ca;
  assign w_vb = i_b ^ i_cb;
  assign w_vc = i_c ^ i_cc;
  assign o_y  = (w_va & w_vb) | (w_va & w_vc) | (w_vb & w_vc);

endmodule

// File: rtl/mig_stream_evaluator.sv
// -----------------------------------------------------------------------------
// mig_stream_evaluator
// Consumes a topologically ordered stream of MAJ-node descriptors, evaluates
// each node against a captured primary-input vector and returns the value of
// the output literal given on the last beat.
//   clk, rst        : clock, synchronous active-high reset
//   start, pi_vec   : begin evaluation (IDLE only), PI vector captured on start
//   node_valid/ready: descriptor handshake, one node per cycle
//   node_lit_a/b/c  : fanin literals {index, complement}
//   node_last       : final descriptor; out_lit sampled with it
//   busy, done      : not-IDLE flag, one-cycle completion pulse
//   po, err         : evaluated output and malformed-stream flag (held)
// -----------------------------------------------------------------------------
module mig_stream_evaluator
  import mig_pkg::*;
#(
  parameter int NUM_PI    = 4,
  parameter int MAX_NODES = 128,
  parameter int IDX_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [NUM_PI-1:0] pi_vec,
  input  logic             node_valid,
  output logic             node_ready,
  input  logic [IDX_W:0]   node_lit_a,
  input  logic [IDX_W:0]   node_lit_b,
  input  logic [IDX_W:0]   node_lit_c,
  input  logic             node_last,
  input  logic [IDX_W:0]   out_lit,
  output logic             busy,
  output logic             done,
  output logic             po,
  output logic             err
);

  localparam int FIRST = first_node_idx(NUM_PI);
  localparam int CNT_W = $clog2(MAX_NODES + 1);
  localparam int TBL_W = 1 << IDX_W;

  state_t               r_state;
  state_t               w_state_next;
  logic [NUM_PI-1:0]    r_pi;
  logic [MAX_NODES-1:0] r_node_val;
  logic [CNT_W-1:0]     r_count;
  logic [IDX_W:0]       r_out_lit;
  logic                 r_err;
  logic                 r_po;
  logic                 r_done;

  // Whole index space viewed as one vector: const0, PIs, then nodes. Padding
  // up to 2^IDX_W lets any index select it directly; range checks keep the
  // unwritten part from ever being consumed.
  logic [TBL_W-1:0]     w_table;
  logic [IDX_W-1:0]     w_idx_a;
  logic [IDX_W-1:0]     w_idx_b;
  logic [IDX_W-1:0]     w_idx_c;
  logic [IDX_W-1:0]     w_idx_out;
  logic [IDX_W:0]       w_limit;
  logic                 w_accept;
  logic                 w_fwd;
  logic                 w_ovf;
  logic                 w_bad;
  logic                 w_write;
  logic                 w_maj;
  logic                 w_out_oor;

  assign w_table   = TBL_W'({r_node_val, r_pi, 1'b0});
  assign w_idx_a   = IDX_W'(lit_idx(32'(node_lit_a)));
  assign w_idx_b   = IDX_W'(lit_idx(32'(node_lit_b)));
  assign w_idx_c   = IDX_W'(lit_idx(32'(node_lit_c)));
  assign w_idx_out = IDX_W'(lit_idx(32'(r_out_lit)));

  // First index not yet written; one bit wider so it cannot wrap when the
  // table is exactly full.
  assign w_limit   = (IDX_W+1)'(FIRST) + (IDX_W+1)'(r_count);

  assign w_accept  = node_valid & node_ready;
  assign w_fwd     = ({1'b0, w_idx_a} >= w_limit) |
                     ({1'b0, w_idx_b} >= w_limit) |
                     ({1'b0, w_idx_c} >= w_limit);
  assign w_ovf     = (r_count == CNT_W'(MAX_NODES));
  assign w_bad     = w_fwd | w_ovf;
  assign w_write   = w_accept & (r_state == ST_EVAL) & ~w_bad;
  assign w_out_oor = ({1'b0, w_idx_out} >= w_limit);

  mig_maj3 u_maj3 (
    .i_a  (w_table[w_idx_a]),
    .i_b  (w_table[w_idx_b]),
    .i_c  (w_table[w_idx_c]),
    .i_ca (lit_cmp(32'(node_lit_a))),
    .i_cb (lit_cmp(32'(node_lit_b))),
    .i_cc (lit_cmp(32'(node_lit_c))),
    .o_y  (w_maj)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state and handshake outputs
  always_comb begin
    w_state_next = r_state;
    node_ready   = 1'b0;
    busy         = 1'b1;
    case (r_state)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) begin
          w_state_next = ST_EVAL;
        end
      end
      ST_EVAL: begin
        node_ready = 1'b1;
        if (w_accept) begin
          // A bad last beat still resolves directly, carrying err with it.
          if (node_last) begin
            w_state_next = ST_RESOLVE;
          end else if (w_bad) begin
            w_state_next = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        node_ready = 1'b1;
        if (w_accept && node_last) begin
          w_state_next = ST_RESOLVE;
        end
      end
      ST_RESOLVE: begin
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // Control/result datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pi      <= '0;
      r_count   <= '0;
      r_out_lit <= '0;
      r_err     <= 1'b0;
      r_po      <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_pi    <= pi_vec;
            r_count <= '0;
            r_err   <= 1'b0;
          end
        end
        ST_EVAL: begin
          if (w_accept) begin
            if (w_bad) begin
              r_err <= 1'b1;
            end else begin
              r_count <= r_count + 1'b1;
            end
            if (node_last) begin
              r_out_lit <= out_lit;
            end
          end
        end
        ST_RESOLVE: begin
          r_done <= 1'b1;
          if (r_err || w_out_oor) begin
            r_err <= 1'b1;
            r_po  <= 1'b0;
          end else begin
            r_po <= w_table[w_idx_out] ^ lit_cmp(32'(r_out_lit));
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Node value slots; contents beyond the count are never read.
  for (genvar gi = 0; gi < MAX_NODES; gi++) begin : g_slot
    always_ff @(posedge clk) begin
      if (w_write && (r_count == CNT_W'(gi))) begin
        r_node_val[gi] <= w_maj;
      end
    end
  end

  assign done = r_done;
  assign po   = r_po;
  assign err  = r_err;

endmodule
